// File: rtl/rx_oversample_voter.sv
// UART RX oversampling bit voter: mid-bit N-sample majority vote,
// noise flag and bit-period edge counter for arbitrary prescale.
module rx_oversample_voter #(
    parameter int PRESCALE_W = 6,
    parameter int N_SAMP     = 3
) (
    input  logic                  clk_RX,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  dat_samp_en,
    input  logic                  resync,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  bit_done,
    output logic                  sampled_bit,
    output logic                  bit_valid,
    output logic                  noise_flag
);

    localparam int H  = (N_SAMP - 1) / 2;
    localparam int CW = $clog2(N_SAMP + 1);

    localparam logic [PRESCALE_W-1:0] PS_MIN = PRESCALE_W'(N_SAMP + 1);
    localparam logic [PRESCALE_W-1:0] H_W    = PRESCALE_W'(H);
    localparam logic [PRESCALE_W-1:0] ONE_W  = PRESCALE_W'(1);
    localparam logic [CW-1:0]         H_C    = CW'(H);
    localparam logic [CW-1:0]         N_C    = CW'(N_SAMP);
    localparam logic [CW-1:0]         ZERO_C = '0;

    generate
        if (N_SAMP != 3 && N_SAMP != 5) begin : g_bad_nsamp
            $error("N_SAMP must be 3 or 5");
        end
    endgenerate

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_W-1:0] ps_q, ps_d;
    logic [N_SAMP-1:0]     sreg_q, sreg_d;
    logic                  sampled_bit_q, sampled_bit_d;
    logic                  bit_valid_q, bit_valid_d;
    logic                  noise_flag_q, noise_flag_d;

    logic [PRESCALE_W-1:0] ps_eff;
    logic [PRESCALE_W-1:0] mid;
    logic [PRESCALE_W-1:0] win_lo;
    logic [PRESCALE_W-1:0] win_hi;
    logic [PRESCALE_W-1:0] last_cnt;
    logic                  active;
    logic                  wrap;
    logic                  in_window;
    logic                  vote;
    logic [CW-1:0]         ones;

    always_comb begin
        ps_eff    = (prescale < PS_MIN) ? PS_MIN : prescale;
        mid       = ps_q >> 1;
        win_lo    = mid - H_W;
        win_hi    = mid + H_W;
        last_cnt  = ps_q - ONE_W;
        active    = dat_samp_en & ~resync;
        wrap      = active & (edge_cnt_q == last_cnt);
        in_window = active & (edge_cnt_q >= win_lo) & (edge_cnt_q <= win_hi);
        vote      = active & (edge_cnt_q == win_hi);
    end

    // Register is cleared at every bit boundary, so at the vote it holds
    // the N_SAMP-1 earlier window samples with its top bit still zero.
    always_comb begin
        ones = {{(CW-1){1'b0}}, RX_IN};
        for (int i = 0; i < N_SAMP; i++) begin
            ones = ones + {{(CW-1){1'b0}}, sreg_q[i]};
        end
    end

    always_comb begin
        edge_cnt_d    = edge_cnt_q;
        ps_d          = ps_q;
        sreg_d        = sreg_q;
        sampled_bit_d = sampled_bit_q;
        noise_flag_d  = noise_flag_q;
        bit_valid_d   = 1'b0;
        if (!dat_samp_en) begin
            edge_cnt_d    = '0;
            ps_d          = ps_eff;
            sreg_d        = '0;
            sampled_bit_d = 1'b0;
            noise_flag_d  = 1'b0;
        end else if (resync) begin
            edge_cnt_d = '0;
            sreg_d     = '0;
        end else begin
            edge_cnt_d = wrap ? '0 : edge_cnt_q + ONE_W;
            if (wrap) begin
                ps_d   = ps_eff;
                sreg_d = '0;
            end else if (in_window) begin
                sreg_d = {sreg_q[N_SAMP-2:0], RX_IN};
            end
            if (vote) begin
                sampled_bit_d = (ones > H_C);
                noise_flag_d  = (ones != ZERO_C) && (ones != N_C);
                bit_valid_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_RX or negedge rst) begin
        if (!rst) begin
            edge_cnt_q    <= '0;
            ps_q          <= PS_MIN;
            sreg_q        <= '0;
            sampled_bit_q <= 1'b0;
            bit_valid_q   <= 1'b0;
            noise_flag_q  <= 1'b0;
        end else begin
            edge_cnt_q    <= edge_cnt_d;
            ps_q          <= ps_d;
            sreg_q        <= sreg_d;
            sampled_bit_q <= sampled_bit_d;
            bit_valid_q   <= bit_valid_d;
            noise_flag_q  <= noise_flag_d;
        end
    end

    assign edge_cnt    = edge_cnt_q;
    assign bit_done    = wrap;
    assign sampled_bit = sampled_bit_q;
    assign bit_valid   = bit_valid_q;
    assign noise_flag  = noise_flag_q;

endmodule
